// File: rtl/bp_pkg.sv
// Shared types and index/counter helpers for the gshare direction/target predictor.
package bp_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } bp_state_e;

    function automatic logic [3:0] sat_step(input logic [3:0] ctr, input logic taken,
                                           input int ctr_bits);
        logic [3:0] ctr_max;
        ctr_max = 4'((1 << ctr_bits) - 1);
        if (taken) begin
            return (ctr == ctr_max) ? ctr : ctr + 4'd1;
        end
        return (ctr == 4'd0) ? ctr : ctr - 4'd1;
    endfunction

    function automatic logic [31:0] pht_index(input logic [31:0] pc, input logic [31:0] ghr,
                                              input int idx_bits);
        return ((pc >> 2) ^ ghr) & ((32'd1 << idx_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] btb_tag(input logic [31:0] pc, input int idx_bits,
                                            input int tag_bits);
        return (pc >> (idx_bits + 2)) & ((32'd1 << tag_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/bp_sat_counter_table.sv
// Pattern history table: saturating counters with an init write port that has
// priority over training, plus a combinational taken read.
module bp_sat_counter_table
    import bp_pkg::*;
#(
    parameter int ENTRIES  = 1024,
    parameter int CTR_BITS = 2
) (
    input  logic                       clk,
    input  logic                       init_we_i,
    input  logic [$clog2(ENTRIES)-1:0] init_idx_i,
    input  logic [$clog2(ENTRIES)-1:0] rd_idx_i,
    output logic                       rd_taken_o,
    input  logic                       upd_we_i,
    input  logic [$clog2(ENTRIES)-1:0] upd_idx_i,
    input  logic                       upd_taken_i
);

    localparam logic [CTR_BITS-1:0] WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    logic [CTR_BITS-1:0] ctr_q [ENTRIES];

    // No array reset: the owner sweeps every entry back to WNT after reset.
    always_ff @(posedge clk) begin
        if (init_we_i) begin
            ctr_q[init_idx_i] <= WNT;
        end else if (upd_we_i) begin
            ctr_q[upd_idx_i] <= CTR_BITS'(sat_step(4'(ctr_q[upd_idx_i]), upd_taken_i, CTR_BITS));
        end
    end

    assign rd_taken_o = ctr_q[rd_idx_i][CTR_BITS-1];

endmodule

// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor with a partially-tagged BTB and speculative GHR.
// state   | meaning
// ST_INIT | sweeping PHT to WNT and BTB valids to 0; predictions and training suppressed
// ST_RUN  | predicting, training and tracking global history
module gshare_branch_predictor
    import bp_pkg::*;
#(
    parameter int PHT_ENTRIES = 1024,
    parameter int BTB_ENTRIES = 256,
    parameter int CTR_BITS    = 2,
    parameter int GHR_BITS    = 8,
    parameter int TAG_BITS    = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                ready_o,
    input  logic                pred_valid_i,
    input  logic [31:0]         pred_pc_i,
    output logic                pred_hit_o,
    output logic                pred_taken_o,
    output logic [31:0]         pred_target_o,
    output logic [GHR_BITS-1:0] pred_ghr_o,
    input  logic                upd_valid_i,
    input  logic [31:0]         upd_pc_i,
    input  logic                upd_taken_i,
    input  logic [31:0]         upd_target_i,
    input  logic [GHR_BITS-1:0] upd_ghr_i,
    input  logic                upd_mispredict_i
);

    localparam int PI    = $clog2(PHT_ENTRIES);
    localparam int BI    = $clog2(BTB_ENTRIES);
    localparam int SWEEP = (PHT_ENTRIES > BTB_ENTRIES) ? PHT_ENTRIES : BTB_ENTRIES;
    localparam int SW    = $clog2(SWEEP);

    bp_state_e           state_q, state_d;
    logic [SW-1:0]       idx_q, idx_d;
    logic [GHR_BITS-1:0] ghr_q, ghr_d;

    logic                btb_valid_q [BTB_ENTRIES];
    logic [TAG_BITS-1:0] btb_tag_q   [BTB_ENTRIES];
    logic [31:0]         btb_tgt_q   [BTB_ENTRIES];

    logic                ready;
    logic                pred_hit;
    logic                pht_taken;
    logic                upd_en;
    logic                init_pht_we;
    logic                init_btb_we;
    logic [BI-1:0]       pred_bidx;
    logic [BI-1:0]       upd_bidx;
    logic [TAG_BITS-1:0] pred_tag;
    logic [PI-1:0]       pred_pidx;
    logic [PI-1:0]       upd_pidx;
    logic [PI-1:0]       init_pidx;

    assign ready       = (state_q == ST_RUN);
    assign upd_en      = ready & upd_valid_i;
    assign init_pht_we = !ready && (32'(idx_q) < 32'(PHT_ENTRIES));
    assign init_btb_we = !ready && (32'(idx_q) < 32'(BTB_ENTRIES));
    assign init_pidx   = PI'(idx_q);

    assign pred_bidx = BI'(pred_pc_i >> 2);
    assign upd_bidx  = BI'(upd_pc_i >> 2);
    assign pred_tag  = TAG_BITS'(btb_tag(pred_pc_i, BI, TAG_BITS));
    assign pred_pidx = PI'(pht_index(pred_pc_i, 32'(ghr_q), PI));
    assign upd_pidx  = PI'(pht_index(upd_pc_i, 32'(upd_ghr_i), PI));

    assign pred_hit = ready & pred_valid_i & btb_valid_q[pred_bidx] &
                      (btb_tag_q[pred_bidx] == pred_tag);

    bp_sat_counter_table #(
        .ENTRIES  (PHT_ENTRIES),
        .CTR_BITS (CTR_BITS)
    ) u_pht (
        .clk         (clk),
        .init_we_i   (init_pht_we),
        .init_idx_i  (init_pidx),
        .rd_idx_i    (pred_pidx),
        .rd_taken_o  (pht_taken),
        .upd_we_i    (upd_en),
        .upd_idx_i   (upd_pidx),
        .upd_taken_i (upd_taken_i)
    );

    // Only valid bits are swept; tag/target are never read while valid is clear.
    always_ff @(posedge clk) begin
        if (init_btb_we) begin
            btb_valid_q[BI'(idx_q)] <= 1'b0;
        end else if (upd_en && upd_taken_i) begin
            btb_valid_q[upd_bidx] <= 1'b1;
            btb_tag_q[upd_bidx]   <= TAG_BITS'(btb_tag(upd_pc_i, BI, TAG_BITS));
            btb_tgt_q[upd_bidx]   <= upd_target_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
            ghr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ghr_q   <= ghr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ghr_d   = ghr_q;
        unique case (state_q)
            ST_INIT: begin
                idx_d = idx_q + SW'(1);
                if (idx_q == SW'(SWEEP - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Execute-stage recovery wins over this cycle's speculative shift.
                if (upd_valid_i && upd_mispredict_i) begin
                    ghr_d = {upd_ghr_i[GHR_BITS-2:0], upd_taken_i};
                end else if (pred_hit) begin
                    ghr_d = {ghr_q[GHR_BITS-2:0], pht_taken};
                end
            end
        endcase
    end

    assign ready_o       = ready;
    assign pred_hit_o    = pred_hit;
    assign pred_taken_o  = pred_hit & pht_taken;
    assign pred_target_o = pred_hit ? btb_tgt_q[pred_bidx] : 32'd0;
    assign pred_ghr_o    = ghr_q;

endmodule

// File: doc/gshare_branch_predictor.md
# gshare_branch_predictor

Parametrised next-generation direction/target predictor for the IFU fetch stage. It combines a gshare pattern history table (PC XOR global history) of N-bit saturating counters with a partially-tagged direct-mapped BTB. It keeps a speculative global history register with mispredict recovery, and clears its tables with a sequential init sweep instead of a single-cycle array reset. Prediction is combinational in the fetch cycle; training arrives from the execute stage.

## Interface
- PHT_ENTRIES, 1024, PHT depth; power of two, ≥ 2^GHR_BITS
- BTB_ENTRIES, 256, BTB depth; power of two
- CTR_BITS, 2, saturating counter width; range 2..4
- GHR_BITS, 8, global history length; ≤ log2(PHT_ENTRIES)
- TAG_BITS, 12, BTB partial tag width
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset: asynchronous, active-low
- ready  out  1  high once the init sweep has completed
- pred_valid  in  1  fetch requests a prediction for pred_pc
- pred_pc  in  32  fetch PC
- pred_hit  out  1  BTB tag hit
- pred_taken  out  1  predicted taken
- pred_target  out  32  predicted target; 0 when there is no hit
- pred_ghr  out  GHR_BITS  current GHR snapshot; the pipeline carries it to execute
- upd_valid  in  1  training event
- upd_pc  in  32  PC of the resolved branch
- upd_taken  in  1  actual direction
- upd_target  in  32  actual target
- upd_ghr  in  GHR_BITS  pred_ghr value captured when this branch was predicted
- upd_mispredict  in  1  direction or target mispredicted; triggers GHR recovery

## Operation
**Index and tag widths**
- PI = log2(PHT_ENTRIES), BI = log2(BTB_ENTRIES).
- pht_idx = pc[PI+1:2] XOR zero-extended ghr.
- btb_idx = pc[BI+1:2].
- tag = pc[BI+TAG_BITS+1:BI+2].

**Counters**
- Counter init value is WNT = 2^(CTR_BITS-1) − 1.
- Predict taken when the counter MSB = 1.
- Increment on taken, saturating at 2^CTR_BITS − 1.
- Decrement on not-taken, saturating at 0.

**Init/run state machine (INIT, RUN)**
- Reset: state = INIT, sweep index = 0, GHR = 0.
- INIT, each cycle: if index < PHT_ENTRIES, PHT[index] ← WNT. If index < BTB_ENTRIES, BTB valid[index] ← 0. Then index increments.
- INIT lasts max(PHT_ENTRIES, BTB_ENTRIES) cycles, then the state goes to RUN.
- ready = (state == RUN).

**Prediction (combinational)**
- pred_hit = ready & pred_valid & valid[btb_idx] & tag match.
- pred_taken = pred_hit & counter MSB, where the counter is read at pht_idx of (pred_pc, GHR).
- pred_target = BTB target on a hit, otherwise 0.
- pred_ghr = GHR at all times.

**Training (RUN only; updates are dropped during INIT)**
- On upd_valid, the PHT counter at pht_idx(upd_pc, upd_ghr) steps toward upd_taken.
- If upd_taken, the BTB entry at btb_idx(upd_pc) is written: valid = 1, tag, target. A not-taken update leaves the BTB unchanged.

**GHR**
- Speculative: if pred_hit, GHR ← {GHR[GHR_BITS-2:0], pred_taken}.
- Recovery: if upd_valid & upd_mispredict, GHR ← {upd_ghr[GHR_BITS-2:0], upd_taken}. Recovery overrides a speculative shift in the same cycle.
- Otherwise GHR holds.

## Timing
- Prediction has zero-cycle latency; outputs are valid in the same cycle as pred_pc.
- Training and GHR writes take effect at the next rising edge.
- Same-cycle prediction and update to the same entry: the prediction sees the pre-update contents (no bypass).
- Reset values: ready = 0, pred_hit = 0, pred_taken = 0, pred_target = 0, pred_ghr = 0.
- ready rises exactly max(PHT_ENTRIES, BTB_ENTRIES) rising edges after rst_n deasserts.
- Reset asserted mid-operation: outputs drop to their reset values immediately (asynchronously), and the init sweep restarts from 0. No state survives.
- Inputs are don't-care during INIT; the GHR stays at 0.

## Structure
- bp_pkg holds:
  - the state enum (INIT, RUN);
  - the function sat_step(ctr, taken, CTR_BITS) returning the next counter value;
  - the functions pht_index and btb_tag for the index and tag calculations.
- One sub-module, bp_sat_counter_table: the PHT array, its init write port, and saturating update. The BTB, GHR and FSM stay in the top module.

## Test plan
Benches use PHT=16, BTB=8, GHR=4, TAG=4, CTR=2 unless stated otherwise.
- **Init sweep:** release rst_n → ready = 0 for 16 cycles, then 1. Drive pred_valid with any PC during INIT → pred_hit = 0.
- **Taken training:** in RUN with GHR = 0, drive upd pc = 0x100, taken, target = 0x200, upd_ghr = 0 → next cycle, predicting 0x100 gives pred_hit = 1, pred_taken = 1 (counter 01→10), pred_target = 0x200.
- **Saturation:** 3 taken updates, then 4 not-taken updates → counter 11 then 00. One further taken update → counter 01, and pred_taken = 0 with pred_hit = 1.
- **Recovery precedence:** GHR = 0x5 plus a pred_hit with pred_taken = 1, in the same cycle as upd_mispredict with upd_ghr = 0x3, upd_taken = 1 → GHR = 0x7, not 0xB.
- **Tag alias:** train 0x100 taken, then predict 0x120 (same btb_idx, different tag) → pred_hit = 0, pred_target = 0. The 0x100 entry is unaffected.
- **Reset mid-run:** pull rst_n low for 1 cycle while in RUN with trained entries → ready and pred_ghr are 0 immediately, init runs for 16 cycles, then predicting 0x100 → pred_hit = 0.
